// File: rtl/instr_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : instr_mem_pkg
//  Description : Shared opcodes, default NOP word and the controller states
//                of the loadable instruction memory.
//  Revision    : 1.0 - initial release
// ============================================================================
package instr_mem_pkg;

  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_SUB   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0100;
  localparam logic [3:0] OP_XOR   = 4'b0101;
  localparam logic [3:0] OP_SL    = 4'b0110;
  localparam logic [3:0] OP_LOAD  = 4'b1010;
  localparam logic [3:0] OP_STORE = 4'b1011;
  localparam logic [3:0] OP_BZ    = 4'b1100;

  localparam logic [15:0] NOP_WORD_DEFAULT = 16'h0000;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } mem_state_e;

endpackage : instr_mem_pkg
`default_nettype wire

// File: rtl/instr_mem_array.sv
`default_nettype none
// ============================================================================
//  Module      : instr_mem_array
//  Description : Single write port, single registered read port with read
//                enable; a same-address write is forwarded to the read data.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_mem_array #(
  parameter int          IW    = 16,
  parameter int          AW    = 8,
  parameter int unsigned DEPTH = 256
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [IW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [IW-1:0] rdata_o
);

  logic [IW-1:0] mem_q [DEPTH];
  logic [IW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= (we_i && (waddr_i == raddr_i)) ? wdata_i : mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule : instr_mem_array
`default_nettype wire

// File: rtl/instr_mem_sync.sv
`default_nettype none
// ============================================================================
//  Module      : instr_mem_sync
//  Description : Loadable program memory with reset NOP sweep, run-time
//                loader port and registered, stallable fetch port.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_mem_sync
  import instr_mem_pkg::*;
#(
  parameter int            IW       = 16,
  parameter int            AW       = 8,
  parameter int unsigned   DEPTH    = 256,
  parameter logic [IW-1:0] NOP_WORD = IW'(NOP_WORD_DEFAULT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [IW-1:0] ld_data,
  output logic          ld_ready,
  output logic          busy,
  input  logic          fetch_en,
  input  logic          stall,
  input  logic [15:0]   pc_out,
  output logic [IW-1:0] instr_out,
  output logic [15:0]   instr_pc,
  output logic          instr_valid,
  output logic          addr_fault,
  output logic          ld_fault
);

  mem_state_e    state_q, state_d;
  logic [AW:0]   clr_cnt_q, clr_cnt_d;
  logic          nop_sel_q;
  logic [15:0]   instr_pc_q;
  logic          valid_q;
  logic          afault_q;
  logic          ldfault_q;

  logic          run;
  logic          clr_last;
  logic          pc_in_range;
  logic          ld_in_range;
  logic          fetch_go;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [IW-1:0] mem_wdata;
  logic          mem_re;
  logic [IW-1:0] mem_rdata;

  assign run         = (state_q == ST_RUN);
  assign clr_last    = (32'(clr_cnt_q) == (DEPTH - 1));
  assign pc_in_range = (32'(pc_out) < DEPTH);
  assign ld_in_range = (32'(ld_addr) < DEPTH);
  assign fetch_go    = run && !stall && fetch_en;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      ST_CLEAR: begin
        clr_cnt_d = clr_cnt_q + (AW+1)'(1);
        if (clr_last) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_CLEAR;
    endcase
  end

  // The sweep owns the write port until RUN; the loader takes it afterwards.
  assign mem_we    = !rst && (run ? (ld_en && ld_in_range) : 1'b1);
  assign mem_waddr = run ? ld_addr : clr_cnt_q[AW-1:0];
  assign mem_wdata = run ? ld_data : NOP_WORD;
  assign mem_re    = !rst && fetch_go && pc_in_range;

  instr_mem_array #(
    .IW    (IW),
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_array (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (mem_waddr),
    .wdata_i (mem_wdata),
    .re_i    (mem_re),
    .raddr_i (pc_out[AW-1:0]),
    .rdata_o (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_CLEAR;
      clr_cnt_q  <= '0;
      nop_sel_q  <= 1'b1;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
      afault_q   <= 1'b0;
      ldfault_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      ldfault_q <= run && ld_en && !ld_in_range;
      if (!run) begin
        valid_q  <= 1'b0;
        afault_q <= 1'b0;
      end else if (!stall) begin
        if (fetch_en) begin
          valid_q    <= 1'b1;
          afault_q   <= !pc_in_range;
          nop_sel_q  <= !pc_in_range;
          instr_pc_q <= pc_out;
        end else begin
          valid_q  <= 1'b0;
          afault_q <= 1'b0;
        end
      end
    end
  end

  // nop_sel_q only changes on an accepted fetch, so instr_out holds with the array data.
  assign instr_out   = nop_sel_q ? NOP_WORD : mem_rdata;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = valid_q;
  assign addr_fault  = afault_q;
  assign ld_fault    = ldfault_q;
  assign busy        = !run;
  assign ld_ready    = run;

endmodule : instr_mem_sync
`default_nettype wire

// File: tb/tb_instr_mem_sync.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_mem_sync
//  Description : Self-checking bench: one 256-word and one 200-word memory,
//                directed vector table plus randomized traffic vs. a model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_mem_sync;

  localparam int          DEPTH_A = 256;
  localparam int          DEPTH_B = 200;
  localparam logic [15:0] NOP     = 16'h0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        a_ld_en = 0, a_fetch_en = 0, a_stall = 0;
  logic [7:0]  a_ld_addr = 0;
  logic [15:0] a_ld_data = 0, a_pc = 0;
  logic        a_ld_ready, a_busy, a_valid, a_fault, a_ldf;
  logic [15:0] a_instr, a_ipc;

  logic        b_ld_en = 0, b_fetch_en = 0, b_stall = 0;
  logic [7:0]  b_ld_addr = 0;
  logic [15:0] b_ld_data = 0, b_pc = 0;
  logic        b_ld_ready, b_busy, b_valid, b_fault, b_ldf;
  logic [15:0] b_instr, b_ipc;

  instr_mem_sync #(.IW(16), .AW(8), .DEPTH(DEPTH_A), .NOP_WORD(NOP)) dut_a (
    .clk(clk), .rst(rst), .ld_en(a_ld_en), .ld_addr(a_ld_addr), .ld_data(a_ld_data),
    .ld_ready(a_ld_ready), .busy(a_busy), .fetch_en(a_fetch_en), .stall(a_stall),
    .pc_out(a_pc), .instr_out(a_instr), .instr_pc(a_ipc), .instr_valid(a_valid),
    .addr_fault(a_fault), .ld_fault(a_ldf)
  );

  instr_mem_sync #(.IW(16), .AW(8), .DEPTH(DEPTH_B), .NOP_WORD(NOP)) dut_b (
    .clk(clk), .rst(rst), .ld_en(b_ld_en), .ld_addr(b_ld_addr), .ld_data(b_ld_data),
    .ld_ready(b_ld_ready), .busy(b_busy), .fetch_en(b_fetch_en), .stall(b_stall),
    .pc_out(b_pc), .instr_out(b_instr), .instr_pc(b_ipc), .instr_valid(b_valid),
    .addr_fault(b_fault), .ld_fault(b_ldf)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model of memory A: contents plus remaining clear cycles.
  logic [15:0] m_mem [DEPTH_A];
  int          m_left;
  logic [15:0] m_instr, m_pc;
  logic        m_valid, m_fault, m_ldf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      m_left = DEPTH_A;
      for (int i = 0; i < DEPTH_A; i++) m_mem[i] = NOP;
      m_instr = NOP; m_pc = 0; m_valid = 0; m_fault = 0; m_ldf = 0;
    end else if (m_left > 0) begin
      m_left--;
      m_valid = 0; m_fault = 0; m_ldf = 0;
    end else begin
      if (!a_stall) begin
        if (a_fetch_en) begin
          m_pc    = a_pc;
          m_valid = 1;
          if (int'(a_pc) >= DEPTH_A) begin
            m_instr = NOP; m_fault = 1;
          end else begin
            m_fault = 0;
            m_instr = (a_ld_en && int'(a_ld_addr) == int'(a_pc)) ? a_ld_data : m_mem[a_pc];
          end
        end else begin
          m_valid = 0; m_fault = 0;
        end
      end
      m_ldf = a_ld_en && (int'(a_ld_addr) >= DEPTH_A);
      if (a_ld_en && int'(a_ld_addr) < DEPTH_A) m_mem[a_ld_addr] = a_ld_data;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic chk_model();
    chk("instr_out",   a_instr,    m_instr);
    chk("instr_pc",    a_ipc,      m_pc);
    chk("instr_valid", a_valid,    m_valid);
    chk("addr_fault",  a_fault,    m_fault);
    chk("ld_fault",    a_ldf,      m_ldf);
    chk("busy",        a_busy,     m_left > 0);
    chk("ld_ready",    a_ld_ready, m_left == 0);
  endtask

  task automatic a_idle();
    a_ld_en = 0; a_fetch_en = 0; a_stall = 0;
  endtask

  // Counts busy cycles of both memories starting from the current sample.
  task automatic measure_sweep(input string tag);
    int na = 0, nb = 0, n = 0;
    while ((a_busy || b_busy) && n < 1000) begin
      if (a_busy) na++;
      if (b_busy) nb++;
      n++;
      tick();
    end
    chk({tag, "_busy_cycles_a"}, na, DEPTH_A);
    chk({tag, "_busy_cycles_b"}, nb, DEPTH_B);
    chk({tag, "_ld_ready_b"}, b_ld_ready, 1);
  endtask

  task automatic fetch_all(input string tag);
    for (int p = 0; p < DEPTH_A; p++) begin
      a_ld_en = 0; a_stall = 0; a_fetch_en = 1; a_pc = 16'(p);
      tick();
      chk_model();
      if (a_instr !== NOP) chk({tag, "_nop"}, a_instr, NOP);
    end
    a_idle();
  endtask

  typedef struct {
    logic        ld_en;
    logic [7:0]  ld_addr;
    logic [15:0] ld_data;
    logic        fetch_en;
    logic        stall;
    logic [15:0] pc;
    logic [15:0] e_instr;
    logic [15:0] e_pc;
    logic        e_valid;
    logic        e_fault;
  } vec_t;

  vec_t tbl [17];

  initial begin
    tbl[0]  = '{1'b1, 8'd0, 16'hB683, 1'b0, 1'b0, 16'd0,     16'h0000, 16'd255,   1'b0, 1'b0};
    tbl[1]  = '{1'b1, 8'd1, 16'h1E80, 1'b0, 1'b0, 16'd0,     16'h0000, 16'd255,   1'b0, 1'b0};
    tbl[2]  = '{1'b0, 8'd0, 16'h0000, 1'b1, 1'b0, 16'd0,     16'hB683, 16'd0,     1'b1, 1'b0};
    tbl[3]  = '{1'b0, 8'd0, 16'h0000, 1'b1, 1'b0, 16'd1,     16'h1E80, 16'd1,     1'b1, 1'b0};
    tbl[4]  = '{1'b1, 8'd5, 16'h5555, 1'b0, 1'b0, 16'd0,     16'h1E80, 16'd1,     1'b0, 1'b0};
    tbl[5]  = '{1'b1, 8'd9, 16'h9999, 1'b0, 1'b0, 16'd0,     16'h1E80, 16'd1,     1'b0, 1'b0};
    tbl[6]  = '{1'b0, 8'd0, 16'h0000, 1'b1, 1'b0, 16'd5,     16'h5555, 16'd5,     1'b1, 1'b0};
    tbl[7]  = '{1'b0, 8'd0, 16'h0000, 1'b1, 1'b1, 16'd6,     16'h5555, 16'd5,     1'b1, 1'b0};
    tbl[8]  = '{1'b1, 8'd5, 16'hAAAA, 1'b1, 1'b1, 16'd9,     16'h5555, 16'd5,     1'b1, 1'b0};
    tbl[9]  = '{1'b0, 8'd0, 16'h0000, 1'b1, 1'b1, 16'd9,     16'h5555, 16'd5,     1'b1, 1'b0};
    tbl[10] = '{1'b0, 8'd0, 16'h0000, 1'b1, 1'b0, 16'd9,     16'h9999, 16'd9,     1'b1, 1'b0};
    tbl[11] = '{1'b0, 8'd0, 16'h0000, 1'b1, 1'b0, 16'd256,   16'h0000, 16'd256,   1'b1, 1'b1};
    tbl[12] = '{1'b0, 8'd0, 16'h0000, 1'b1, 1'b1, 16'd3,     16'h0000, 16'd256,   1'b1, 1'b1};
    tbl[13] = '{1'b0, 8'd0, 16'h0000, 1'b0, 1'b0, 16'd3,     16'h0000, 16'd256,   1'b0, 1'b0};
    tbl[14] = '{1'b0, 8'd0, 16'h0000, 1'b1, 1'b0, 16'hFFFF,  16'h0000, 16'hFFFF,  1'b1, 1'b1};
    tbl[15] = '{1'b1, 8'd7, 16'hC03A, 1'b1, 1'b0, 16'd7,     16'hC03A, 16'd7,     1'b1, 1'b0};
    tbl[16] = '{1'b0, 8'd0, 16'h0000, 1'b1, 1'b0, 16'd5,     16'hAAAA, 16'd5,     1'b1, 1'b0};

    // Reset held for two edges, then the reset state is checked.
    rst = 1;
    tick();
    tick();
    chk("rst_busy",     a_busy,     1);
    chk("rst_ld_ready", a_ld_ready, 0);
    chk("rst_instr",    a_instr,    NOP);
    chk("rst_pc",       a_ipc,      0);
    chk("rst_valid",    a_valid,    0);
    chk("rst_fault",    a_fault,    0);
    chk("rst_ld_fault", a_ldf,      0);
    rst = 0;
    measure_sweep("init");
    chk_model();
    fetch_all("init");

    // 200-word memory: out-of-range load faults and is dropped.
    b_ld_en = 1; b_ld_addr = 8'd210; b_ld_data = 16'h1234;
    tick();
    chk("b_ld_fault_pulse", b_ldf, 1);
    b_ld_addr = 8'd199; b_ld_data = 16'hBEEF;
    tick();
    chk("b_ld_fault_clear", b_ldf, 0);
    b_ld_en = 0; b_fetch_en = 1; b_pc = 16'd199;
    tick();
    chk("b_last_word",  b_instr, 16'hBEEF);
    chk("b_last_fault", b_fault, 0);
    b_pc = 16'd200;
    tick();
    chk("b_oor_instr", b_instr, NOP);
    chk("b_oor_fault", b_fault, 1);
    chk("b_oor_valid", b_valid, 1);
    b_pc = 16'd210;
    tick();
    chk("b_210_instr", b_instr, NOP);
    chk("b_210_fault", b_fault, 1);
    b_fetch_en = 0;

    a_idle();
    foreach (tbl[i]) begin
      a_ld_en = tbl[i].ld_en; a_ld_addr = tbl[i].ld_addr; a_ld_data = tbl[i].ld_data;
      a_fetch_en = tbl[i].fetch_en; a_stall = tbl[i].stall; a_pc = tbl[i].pc;
      tick();
      chk($sformatf("vec%0d_instr", i), a_instr, tbl[i].e_instr);
      chk($sformatf("vec%0d_pc", i),    a_ipc,   tbl[i].e_pc);
      chk($sformatf("vec%0d_valid", i), a_valid, tbl[i].e_valid);
      chk($sformatf("vec%0d_fault", i), a_fault, tbl[i].e_fault);
    end

    // Randomized traffic concentrated on a few addresses to provoke collisions.
    for (int n = 0; n < 400; n++) begin
      a_ld_en    = 1'($urandom_range(0, 1));
      a_ld_addr  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
      a_ld_data  = 16'($urandom);
      a_fetch_en = ($urandom_range(0, 3) != 0);
      a_stall    = ($urandom_range(0, 3) == 0);
      a_pc       = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 15));
      tick();
      chk_model();
    end

    // Restart the sweep from mid-way with traffic that must be ignored.
    a_idle();
    rst = 1;
    tick();
    rst = 0;
    for (int n = 0; n < 100; n++) begin
      a_ld_en = 1; a_ld_addr = 8'($urandom); a_ld_data = 16'($urandom);
      a_fetch_en = 1; a_pc = 16'($urandom_range(0, 255));
      tick();
      chk_model();
    end
    a_idle();
    rst = 1;
    tick();
    rst = 0;
    chk("mid_rst_busy", a_busy, 1);
    measure_sweep("mid");
    fetch_all("mid");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_instr_mem_sync
`default_nettype wire
